mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for bus_ack_i per bus phase.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req_i  input  1  CPU access request, held high until cpu_done_o.
REQ-005 cpu_we_i  input  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 cpu_wdata_i  input  32  store data, lane-aligned.
REQ-008 cpu_sel_i  input  4  byte enables; bit i selects bits [8i+7:8i].
REQ-009 cpu_rdata_o  output  32  load data, valid while cpu_done_o=1.
REQ-010 cpu_done_o  output  1  one-cycle completion pulse.
REQ-011 cpu_err_o  output  1  one-cycle pulse, coincident with cpu_done_o, on timeout.
REQ-012 cpu_stall_o  output  1  combinational: cpu_req_i AND NOT cpu_done_o.
REQ-013 bus_addr_o  output  32  word address = {2'b00, latched addr[31:2]}.
REQ-014 bus_data_o  output  32  write data to RAM slave.
REQ-015 bus_data_i  input  32  read data from RAM slave, sampled on bus_ack_i.
REQ-016 bus_select_o  output  1  bus cycle active.
REQ-017 bus_we_o  output  1  1 = write cycle.
REQ-018 bus_ack_i  input  1  slave completion; ignored while bus_select_o=0.

Function
REQ-019 All bus_* and cpu_* outputs except cpu_stall_o SHALL be registered.
REQ-020 States: IDLE, RD, RMW_RD, GAP, RMW_WR, WR, DONE.
REQ-021 IDLE with cpu_req_i=1 SHALL latch addr/wdata/sel/we and go: load -> RD; store sel=4'b1111 -> WR; store sel=0 -> DONE (no bus cycle); other store -> RMW_RD.
REQ-022 RD/RMW_RD: bus_select_o=1, bus_we_o=0; WR/RMW_WR: bus_select_o=1, bus_we_o=1, bus_data_o = write word.
REQ-023 RD on ack: cpu_rdata_o <= bus_data_i (all 32 bits, sel not applied), go DONE.
REQ-024 RMW_RD on ack: merged byte i = sel[i] ? wdata byte i : bus_data_i byte i; go GAP.
REQ-025 GAP: bus_select_o=0 for exactly one cycle, then RMW_WR with merged word.
REQ-026 WR/RMW_WR on ack: go DONE.
REQ-027 bus_select_o SHALL fall in the cycle after ack and stay low at least one cycle between bus cycles.
REQ-028 DONE: cpu_done_o=1 for one cycle, bus_select_o=0, then IDLE; request present in the following IDLE cycle is a new transaction.
REQ-029 Latency: request seen in IDLE at cycle 0 -> bus_select_o=1 at cycle 1; ack at cycle k -> cpu_done_o at cycle k+1.
REQ-030 Wait counter cleared on entry to each bus state, increments each cycle without ack; on reaching TIMEOUT: drop select, cpu_err_o=1, cpu_rdata_o=32'h0, go DONE; any remaining RMW write phase is skipped.
REQ-031 Ack in same cycle counter reaches TIMEOUT SHALL be treated as success.
REQ-032 cpu_req_i falling mid-transaction SHALL NOT abort; transaction completes and pulses cpu_done_o.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, counter 0, and all registered outputs to 0, including mid-bus-cycle.
REQ-034 After rst deasserts, first request SHALL be accepted on the first clk edge with cpu_req_i=1.

Verification
REQ-035 Load addr 0x0000_0010, ack 2 cycles after select -> bus_addr_o=0x4, bus_we_o=0, rdata=0xDEADBEEF at done, done at cycle 4.
REQ-036 Store sel=4'b1111 data 0x12345678 -> single write cycle, bus_data_o=0x12345678, no read phase.
REQ-037 Store sel=4'b0010 data 0x0000AB00, RAM word 0x11223344 -> read, one-cycle select gap, write 0x1122AB44.
REQ-038 Load with no ack, TIMEOUT=8 -> select high 8 cycles, then cpu_done_o=cpu_err_o=1, rdata=0.
REQ-039 rst asserted mid RMW_WR -> outputs 0 same cycle, no done pulse, next load completes normally.
REQ-040 Store sel=4'b0000 -> no bus_select_o, cpu_done_o pulse one cycle after acceptance.

Source files
------------

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - RAM-side bus bundle for mem_bus_master
interface mem_bus_master_if;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_select_o;
  logic        bus_we_o;
  logic        bus_ack_i;

  modport master (
    output bus_addr_o,
    output bus_data_o,
    output bus_select_o,
    output bus_we_o,
    input  bus_data_i,
    input  bus_ack_i
  );

  modport slave (
    input  bus_addr_o,
    input  bus_data_o,
    input  bus_select_o,
    input  bus_we_o,
    output bus_data_i,
    output bus_ack_i
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU load/store to word-wide RAM bus master with byte-merge RMW and timeout
module mem_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  input  logic [3:0]            cpu_sel_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  cpu_done_o,
  output logic                  cpu_err_o,
  output logic                  cpu_stall_o,
  mem_bus_master_if.master      bus
);

  // The wait counter only needs to reach TIMEOUT-1: the cycle that would
  // make it TIMEOUT is the one that declares the timeout.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_GAP,
    S_RMW_WR,
    S_WR,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      wdata_q;   // store data, replaced by the merged word after the RMW read
  logic [3:0]       sel_q;
  logic             wait_expired;
  logic             addr_lsb_unused;

  // Word addressing drops the byte offset entirely.
  assign addr_lsb_unused = ^cpu_addr_i[1:0];

  assign cpu_stall_o  = cpu_req_i & ~cpu_done_o;
  assign wait_expired = (wait_cnt == CNT_LAST);

  // Byte lanes selected by the CPU come from the store data, the rest from RAM.
  function automatic logic [31:0] merge_bytes(input logic [31:0] wr_word,
                                              input logic [31:0] rd_word,
                                              input logic [3:0]  lane_sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_sel[i] ? wr_word[8*i +: 8] : rd_word[8*i +: 8];
    end
    return merged;
  endfunction

  // Transaction FSM; every bus and cpu output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      wdata_q          <= '0;
      sel_q            <= '0;
      cpu_rdata_o      <= '0;
      cpu_done_o       <= 1'b0;
      cpu_err_o        <= 1'b0;
      bus.bus_addr_o   <= '0;
      bus.bus_data_o   <= '0;
      bus.bus_select_o <= 1'b0;
      bus.bus_we_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req_i) begin
            bus.bus_addr_o <= {2'b00, cpu_addr_i[31:2]};
            wdata_q        <= cpu_wdata_i;
            sel_q          <= cpu_sel_i;
            wait_cnt       <= '0;
            cpu_rdata_o    <= '0;
            if (!cpu_we_i) begin
              state            <= S_RD;
              bus.bus_select_o <= 1'b1;
              bus.bus_we_o     <= 1'b0;
            end else if (cpu_sel_i == 4'b1111) begin
              state            <= S_WR;
              bus.bus_select_o <= 1'b1;
              bus.bus_we_o     <= 1'b1;
              bus.bus_data_o   <= cpu_wdata_i;
            end else if (cpu_sel_i == 4'b0000) begin
              // Nothing to write: complete without touching the bus.
              state      <= S_DONE;
              cpu_done_o <= 1'b1;
            end else begin
              state            <= S_RMW_RD;
              bus.bus_select_o <= 1'b1;
              bus.bus_we_o     <= 1'b0;
            end
          end
        end

        S_RD, S_RMW_RD: begin
          if (bus.bus_ack_i) begin
            bus.bus_select_o <= 1'b0;
            if (state == S_RD) begin
              cpu_rdata_o <= bus.bus_data_i;
              cpu_done_o  <= 1'b1;
              state       <= S_DONE;
            end else begin
              wdata_q <= merge_bytes(wdata_q, bus.bus_data_i, sel_q);
              state   <= S_GAP;
            end
          end else if (wait_expired) begin
            // Timeout also abandons the RMW write phase.
            bus.bus_select_o <= 1'b0;
            bus.bus_we_o     <= 1'b0;
            cpu_rdata_o      <= '0;
            cpu_err_o        <= 1'b1;
            cpu_done_o       <= 1'b1;
            state            <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // One idle bus cycle separates the RMW read from its write.
          bus.bus_select_o <= 1'b1;
          bus.bus_we_o     <= 1'b1;
          bus.bus_data_o   <= wdata_q;
          wait_cnt         <= '0;
          state            <= S_RMW_WR;
        end

        S_WR, S_RMW_WR: begin
          if (bus.bus_ack_i) begin
            bus.bus_select_o <= 1'b0;
            bus.bus_we_o     <= 1'b0;
            cpu_done_o       <= 1'b1;
            state            <= S_DONE;
          end else if (wait_expired) begin
            bus.bus_select_o <= 1'b0;
            bus.bus_we_o     <= 1'b0;
            cpu_rdata_o      <= '0;
            cpu_err_o        <= 1'b1;
            cpu_done_o       <= 1'b1;
            state            <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          cpu_done_o <= 1'b0;
          cpu_err_o  <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          bus.bus_select_o <= 1'b0;
          bus.bus_we_o     <= 1'b0;
          cpu_done_o       <= 1'b0;
          cpu_err_o        <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - randomized self-checking bench for mem_bus_master
module tb_mem_bus_master;
  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  mem_bus_master_if bus ();

  mem_bus_master #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (req),
    .cpu_we_i    (we),
    .cpu_addr_i  (addr),
    .cpu_wdata_i (wdata),
    .cpu_sel_i   (sel),
    .cpu_rdata_o (rdata),
    .cpu_done_o  (done),
    .cpu_err_o   (err),
    .cpu_stall_o (stall),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram     [16];
  logic [31:0] ref_mem [16];

  int          d_rd_g = 0;
  int          d_wr_g = 0;
  logic [31:0] exp_addr_g = '0;
  logic [31:0] exp_wword_g = '0;
  int          sel_rises = 0;
  int          s_cnt = 0;
  logic        ack_prev = 1'b0;
  logic        prev_sel = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM slave: acks after a programmed number of wait cycles, checks bus protocol
  always @(negedge clk) begin
    if (rst) begin
      bus.bus_ack_i  = 1'b0;
      bus.bus_data_i = '0;
      s_cnt          = 0;
      ack_prev       = 1'b0;
      prev_sel       = 1'b0;
    end else begin
      if (ack_prev) check("select_after_ack", {31'b0, bus.bus_select_o}, 32'd0);
      ack_prev = 1'b0;
      if (bus.bus_select_o) begin
        if (!prev_sel) sel_rises++;
        check("bus_addr", bus.bus_addr_o, exp_addr_g);
        if (bus.bus_we_o) check("bus_wdata", bus.bus_data_o, exp_wword_g);
        if (s_cnt == (bus.bus_we_o ? d_wr_g : d_rd_g)) begin
          bus.bus_ack_i = 1'b1;
          ack_prev      = 1'b1;
          if (bus.bus_we_o) ram[bus.bus_addr_o[3:0]] = bus.bus_data_o;
          else bus.bus_data_i = ram[bus.bus_addr_o[3:0]];
        end else begin
          bus.bus_ack_i  = 1'b0;
          bus.bus_data_i = $urandom;
          s_cnt++;
        end
      end else begin
        bus.bus_ack_i  = 1'b0;
        bus.bus_data_i = $urandom;
        s_cnt          = 0;
      end
      prev_sel = bus.bus_select_o;
    end
  end

  // One CPU transaction against the reference memory; d_rd/d_wr are wait cycles before ack
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_sel, input int t_drd, input int t_dwr, input int t_drop);
    logic [3:0]  idx;
    logic [31:0] old, mask, merged, e_rdata, new_word;
    logic        e_err, done_seen;
    int          lat, n_bus, base, n;
    idx      = t_addr[5:2];
    old      = ref_mem[idx];
    mask     = {{8{t_sel[3]}}, {8{t_sel[2]}}, {8{t_sel[1]}}, {8{t_sel[0]}}};
    merged   = (t_wdata & mask) | (old & ~mask);
    e_err    = 1'b0;
    e_rdata  = '0;
    new_word = old;
    if (!t_we) begin
      n_bus = 1;
      if (t_drd < TO) begin lat = t_drd + 2; e_rdata = old; end
      else begin lat = TO + 1; e_err = 1'b1; end
    end else if (t_sel == 4'hF) begin
      n_bus = 1;
      if (t_dwr < TO) begin lat = t_dwr + 2; new_word = t_wdata; end
      else begin lat = TO + 1; e_err = 1'b1; end
    end else if (t_sel == 4'h0) begin
      n_bus = 0;
      lat   = 1;
    end else if (t_drd >= TO) begin
      n_bus = 1;
      lat   = TO + 1;
      e_err = 1'b1;
    end else begin
      n_bus = 2;
      if (t_dwr < TO) begin lat = t_drd + t_dwr + 4; new_word = merged; end
      else begin lat = t_drd + TO + 3; e_err = 1'b1; end
    end
    d_rd_g      = t_drd;
    d_wr_g      = t_dwr;
    exp_addr_g  = {2'b00, t_addr[31:2]};
    exp_wword_g = merged;
    base        = sel_rises;
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    sel   = t_sel;
    n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done) done_seen = 1'b1;
      else begin
        check("stall_wait", {31'b0, stall}, {31'b0, req});
        if (n == t_drop) req = 1'b0;
      end
    end
    check("latency", n, lat);
    if (done_seen) begin
      check("err", {31'b0, err}, {31'b0, e_err});
      check("stall_at_done", {31'b0, stall}, 32'd0);
      if (!t_we) check("rdata", rdata, e_rdata);
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("err_pulse", {31'b0, err}, 32'd0);
    check("bus_cycles", sel_rises - base, n_bus);
    ref_mem[idx] = new_word;
    check("ram_word", ram[idx], new_word);
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r < 8) return TO - 1;
    return TO + 5;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_sel;
    logic [31:0] rst_mask, rst_merged, rst_wd;
    int          k;
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    sel   = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check("rst_select", {31'b0, bus.bus_select_o}, 32'd0);
    check("rst_we", {31'b0, bus.bus_we_o}, 32'd0);
    check("rst_addr", bus.bus_addr_o, 32'd0);
    check("rst_data", bus.bus_data_o, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Load right after reset, ack two cycles after select
    ram[4]     = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, 0, 0);
    // Full-word store
    run_txn(1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 0, 1, 0);
    check("full_store_word", ram[8], 32'h12345678);
    // Partial store via read-modify-write
    ram[3]     = 32'h11223344;
    ref_mem[3] = 32'h11223344;
    run_txn(1'b1, 32'h0000_000C, 32'h0000AB00, 4'b0010, 1, 1, 0);
    check("rmw_merge_word", ram[3], 32'h1122AB44);
    // Load with no ack times out
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, TO + 5, 0, 0);
    // Empty store completes without a bus cycle
    run_txn(1'b1, 32'h0000_0044, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    // Ack on the last allowed cycle is a success
    run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, TO - 1, 0, 0);
    run_txn(1'b1, 32'h0000_0018, 32'hCAFEF00D, 4'hF, 0, TO - 1, 0);
    // RMW with write-phase timeout, and with request dropped early
    run_txn(1'b1, 32'h0000_001C, 32'h55AA55AA, 4'b1001, 0, TO + 5, 0);
    run_txn(1'b1, 32'h0000_0028, 32'hA5A5A5A5, 4'b0110, 2, 1, 1);

    // Reset during the RMW write phase
    r_sel      = 4'b0101;
    rst_wd     = $urandom;
    rst_mask   = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
    rst_merged = (rst_wd & rst_mask) | (ref_mem[9] & ~rst_mask);
    d_rd_g      = 0;
    d_wr_g      = 100;
    exp_addr_g  = 32'h9;
    exp_wword_g = rst_merged;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0000_0024;
    wdata = rst_wd;
    sel   = r_sel;
    k = 0;
    while (!(bus.bus_select_o && bus.bus_we_o) && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("reach_rmw_write", {31'b0, (k < 20)}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_select", {31'b0, bus.bus_select_o}, 32'd0);
    check("midrst_we", {31'b0, bus.bus_we_o}, 32'd0);
    check("midrst_addr", bus.bus_addr_o, 32'd0);
    check("midrst_data", bus.bus_data_o, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    run_txn(1'b0, 32'h0000_0024, 32'h0, 4'h0, 1, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic        r_we;
      logic [3:0]  rs;
      int          c;
      r_we = 1'($urandom_range(0, 1));
      c    = $urandom_range(0, 3);
      if (c == 0) rs = 4'hF;
      else if (c == 1) rs = 4'h0;
      else rs = 4'($urandom);
      run_txn(r_we, $urandom, $urandom, rs, pick_delay(), pick_delay(),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
